// File: rtl/inst_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : inst_mem_pkg
//  Description : Shared types, constants and the address-check function for
//                the instruction memory. The same check is applied to the
//                fetch port and the load port so both agree on what a faulted
//                address is.
//  Contents    : fault_e          - response fault code
//                NOP_INST_DEFAULT - instruction returned on a faulted fetch
//                adr_check()      - full-width range/alignment check
//  Revision    : 1.0 - initial release
// ============================================================================
package inst_mem_pkg;

  typedef enum logic [1:0] {
    FLT_OK       = 2'b00,
    FLT_MISALIGN = 2'b01,
    FLT_RANGE    = 2'b10
  } fault_e;

  localparam logic [31:0] NOP_INST_DEFAULT = 32'h0000_0013;

  // Addresses are zero-extended to this width before checking, so the check
  // never truncates an address and a huge address cannot wrap into range.
  localparam int unsigned ADR_MAX_W = 128;

  // Range has priority over alignment: an address past the last whole word
  // is reported as out-of-range even when it is also misaligned.
  function automatic fault_e adr_check(input logic [ADR_MAX_W-1:0] adr,
                                       input int unsigned          depth,
                                       input int unsigned          bpi);
    logic [ADR_MAX_W-1:0] last_ok;
    last_ok = ADR_MAX_W'(depth - bpi);
    if (adr > last_ok) begin
      return FLT_RANGE;
    end
    if ((adr % ADR_MAX_W'(bpi)) != '0) begin
      return FLT_MISALIGN;
    end
    return FLT_OK;
  endfunction

endpackage
`default_nettype wire

// File: rtl/inst_mem_array.sv
`default_nettype none
// ============================================================================
//  Module      : inst_mem_array
//  Description : Byte array holding the program. Byte-enabled synchronous
//                write, combinational little-endian word read. Contents have
//                no reset. The array is named "memory" so it can be preloaded
//                hierarchically.
//  Ports       : clk       - clock
//                we_i      - write strobe (already qualified as non-faulted)
//                wr_adr_i  - write byte address (word base)
//                wr_data_i - write data, byte i goes to wr_adr_i+i
//                wr_be_i   - per-byte write enables
//                rd_adr_i  - read byte address (word base)
//                rd_data_o - {memory[rd_adr_i+BPI-1], ..., memory[rd_adr_i]}
//  Revision    : 1.0 - initial release
// ============================================================================
module inst_mem_array #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned BPI   = 4,
  parameter int unsigned AW    = 6
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [AW-1:0]     wr_adr_i,
  input  logic [8*BPI-1:0]  wr_data_i,
  input  logic [BPI-1:0]    wr_be_i,
  input  logic [AW-1:0]     rd_adr_i,
  output logic [8*BPI-1:0]  rd_data_o
);

  logic [7:0] memory [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int i = 0; i < int'(BPI); i++) begin
        if (wr_be_i[i]) begin
          memory[wr_adr_i + AW'(i)] <= wr_data_i[8*i +: 8];
        end
      end
    end
  end

  // The read index only matters for non-faulted addresses; the caller
  // substitutes a NOP otherwise, so wrap-around here is harmless.
  for (genvar gi = 0; gi < int'(BPI); gi++) begin : g_rd_byte
    assign rd_data_o[8*gi +: 8] = memory[rd_adr_i + AW'(gi)];
  end

endmodule
`default_nettype wire

// File: rtl/inst_mem_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : inst_mem_fetch
//  Description : Instruction memory with a valid/ready fetch port (one-cycle
//                registered read, backpressure, fault reporting) and a
//                byte-enabled load port for writing program words.
//  Ports       : clk, rst (sync, active-low)
//                req_valid/req_ready/req_adr        - fetch request
//                resp_valid/resp_ready/instruction/resp_fault - response
//                ld_we/ld_adr/ld_data/ld_be         - load port
//                ld_err                             - previous load faulted
//  Revision    : 1.0 - initial release
// ============================================================================
module inst_mem_fetch
  import inst_mem_pkg::*;
#(
  parameter int unsigned       ADR_W    = 64,
  parameter int unsigned       INST_W   = 32,
  parameter int unsigned       DEPTH    = 64,
  parameter logic [INST_W-1:0] NOP_INST = INST_W'(NOP_INST_DEFAULT)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADR_W-1:0]      req_adr,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [INST_W-1:0]     instruction,
  output logic [1:0]            resp_fault,
  input  logic                  ld_we,
  input  logic [ADR_W-1:0]      ld_adr,
  input  logic [INST_W-1:0]     ld_data,
  input  logic [INST_W/8-1:0]   ld_be,
  output logic                  ld_err
);

  localparam int unsigned BPI = INST_W / 8;
  localparam int unsigned AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic                resp_valid_q, resp_valid_d;
  logic [INST_W-1:0]   inst_q, inst_d;
  fault_e              fault_q, fault_d;
  logic                ld_err_q, ld_err_d;

  fault_e              req_fault;
  fault_e              ld_fault;
  logic                req_accept;
  logic [INST_W-1:0]   rd_word;

  assign req_fault = adr_check(ADR_MAX_W'(req_adr), DEPTH, BPI);
  assign ld_fault  = adr_check(ADR_MAX_W'(ld_adr), DEPTH, BPI);

  // The output register may be refilled whenever it is empty or being
  // drained this cycle; req_valid never feeds back into req_ready.
  assign req_ready  = !resp_valid_q || resp_ready;
  assign req_accept = req_valid && req_ready;

  // Write happens at the same edge that captures the read data, so a
  // same-cycle load and fetch to one address returns the old word.
  inst_mem_array #(
    .DEPTH (DEPTH),
    .BPI   (BPI),
    .AW    (AW)
  ) u_array (
    .clk       (clk),
    .we_i      (ld_we && (ld_fault == FLT_OK)),
    .wr_adr_i  (ld_adr[AW-1:0]),
    .wr_data_i (ld_data),
    .wr_be_i   (ld_be),
    .rd_adr_i  (req_adr[AW-1:0]),
    .rd_data_o (rd_word)
  );

  always_comb begin
    resp_valid_d = resp_valid_q;
    inst_d       = inst_q;
    fault_d      = fault_q;
    if (req_accept) begin
      resp_valid_d = 1'b1;
      fault_d      = req_fault;
      inst_d       = (req_fault == FLT_OK) ? rd_word : NOP_INST;
    end else if (resp_ready) begin
      resp_valid_d = 1'b0;
    end
    ld_err_d = ld_we && (ld_fault != FLT_OK);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      resp_valid_q <= 1'b0;
      inst_q       <= '0;
      fault_q      <= FLT_OK;
      ld_err_q     <= 1'b0;
    end else begin
      resp_valid_q <= resp_valid_d;
      inst_q       <= inst_d;
      fault_q      <= fault_d;
      ld_err_q     <= ld_err_d;
    end
  end

  assign resp_valid  = resp_valid_q;
  assign instruction = inst_q;
  assign resp_fault  = fault_q;
  assign ld_err      = ld_err_q;

endmodule
`default_nettype wire

// File: tb/tb_inst_mem_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_inst_mem_fetch
//  Description : Self-checking bench for inst_mem_fetch. Directed scenarios
//                followed by randomized traffic, compared every cycle against
//                a byte-array reference model of the memory and response.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_mem_fetch;

  localparam int unsigned ADR_W  = 64;
  localparam int unsigned INST_W = 32;
  localparam int unsigned DEPTH  = 64;
  localparam int unsigned BPI    = INST_W / 8;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic [ADR_W-1:0]  req_adr;
  logic              resp_valid;
  logic              resp_ready;
  logic [INST_W-1:0] instruction;
  logic [1:0]        resp_fault;
  logic              ld_we;
  logic [ADR_W-1:0]  ld_adr;
  logic [INST_W-1:0] ld_data;
  logic [BPI-1:0]    ld_be;
  logic              ld_err;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [7:0]  m_mem [DEPTH];
  logic        m_valid = 1'b0;
  logic [31:0] m_inst  = '0;
  logic [1:0]  m_fault = 2'b00;
  logic        m_lderr = 1'b0;

  inst_mem_fetch #(
    .ADR_W  (ADR_W),
    .INST_W (INST_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_adr     (req_adr),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .instruction (instruction),
    .resp_fault  (resp_fault),
    .ld_we       (ld_we),
    .ld_adr      (ld_adr),
    .ld_data     (ld_data),
    .ld_be       (ld_be),
    .ld_err      (ld_err)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: observed no finish, required finish before time limit");
    $fatal(1, "watchdog");
  end

  function automatic logic [1:0] chk(input logic [63:0] a);
    if (a > 64'(DEPTH - BPI)) return 2'd2;
    if ((a % 64'(BPI)) != 64'd0) return 2'd1;
    return 2'd0;
  endfunction

  function automatic logic [31:0] read_word(input logic [63:0] a);
    logic [31:0] w;
    for (int i = 0; i < int'(BPI); i++) w[8*i +: 8] = m_mem[int'(a) + i];
    return w;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: predict from the currently driven inputs, advance,
  // then compare all outputs against the model.
  task automatic tick();
    logic        acc;
    logic [1:0]  f, lf;
    logic [31:0] w;
    acc = req_valid && (!m_valid || resp_ready);
    f   = chk(req_adr);
    w   = (f == 2'd0) ? read_word(req_adr) : NOP;
    lf  = chk(ld_adr);
    @(posedge clk);
    if (ld_we && lf == 2'd0)
      for (int i = 0; i < int'(BPI); i++)
        if (ld_be[i]) m_mem[int'(ld_adr) + i] = ld_data[8*i +: 8];
    if (!rst) begin
      m_valid = 1'b0;
      m_inst  = '0;
      m_fault = 2'b00;
      m_lderr = 1'b0;
    end else begin
      if (acc) begin
        m_valid = 1'b1;
        m_inst  = w;
        m_fault = f;
      end else if (resp_ready) begin
        m_valid = 1'b0;
      end
      m_lderr = ld_we && (lf != 2'd0);
    end
    #1;
    check("resp_valid", 64'(resp_valid), 64'(m_valid));
    check("ld_err", 64'(ld_err), 64'(m_lderr));
    check("req_ready", 64'(req_ready), 64'(!m_valid || resp_ready));
    if (m_valid) begin
      check("instruction", 64'(instruction), 64'(m_inst));
      check("resp_fault", 64'(resp_fault), 64'(m_fault));
    end
  endtask

  function automatic logic [63:0] rand_adr();
    case ($urandom_range(0, 3))
      0:       return 64'($urandom_range(0, DEPTH / BPI - 1) * BPI);
      1:       return 64'($urandom_range(0, DEPTH + 7));
      2:       return {$urandom, $urandom};
      default: return 64'($urandom_range(0, DEPTH / BPI - 1) * BPI);
    endcase
  endfunction

  logic [7:0] save62, save63;

  initial begin
    rst = 1'b0; req_valid = 1'b0; req_adr = '0; resp_ready = 1'b1;
    ld_we = 1'b0; ld_adr = '0; ld_data = '0; ld_be = '0;

    // Reset state
    tick(); tick();
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_instruction", 64'(instruction), 64'd0);
    check("rst_resp_fault", 64'(resp_fault), 64'd0);
    check("rst_ld_err", 64'(ld_err), 64'd0);
    check("rst_req_ready", 64'(req_ready), 64'd1);
    rst = 1'b1;

    // Preload the whole memory with random words
    ld_we = 1'b1; ld_be = '1;
    for (int a = 0; a < int'(DEPTH); a += int'(BPI)) begin
      ld_adr = 64'(a); ld_data = $urandom; tick();
    end

    // Program two words and fetch them back to back
    ld_adr = 64'd0; ld_data = 32'hFFAA_FFAA; tick();
    ld_adr = 64'd4; ld_data = 32'hAABB_CCDD; tick();
    ld_we = 1'b0;
    check("mem0", 64'(dut.u_array.memory[0]), 64'hAA);
    check("mem7", 64'(dut.u_array.memory[7]), 64'hAA);
    req_valid = 1'b1; req_adr = 64'd0; tick();
    check("fetch0", 64'(instruction), 64'hFFAA_FFAA);
    req_adr = 64'd4; tick();
    check("fetch4", 64'(instruction), 64'hAABB_CCDD);
    check("fetch4_fault", 64'(resp_fault), 64'd0);

    // Fault cases
    req_adr = 64'd64; tick();
    check("range_fault", 64'(resp_fault), 64'd2);
    check("range_inst", 64'(instruction), 64'(NOP));
    req_adr = 64'd2; tick();
    check("mis_fault", 64'(resp_fault), 64'd1);
    check("mis_inst", 64'(instruction), 64'(NOP));
    req_adr = 64'hFFFF_FFFF_FFFF_FFFC; tick();
    check("wrap_fault", 64'(resp_fault), 64'd2);
    req_valid = 1'b0; tick();

    // Backpressure
    resp_ready = 1'b0; req_valid = 1'b1; req_adr = 64'd0; tick();
    req_adr = 64'd4;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("bp_hold_inst", 64'(instruction), 64'hFFAA_FFAA);
      check("bp_req_ready", 64'(req_ready), 64'd0);
    end
    resp_ready = 1'b1; #1;
    check("bp_ready_comb", 64'(req_ready), 64'd1);
    tick();
    check("bp_release", 64'(instruction), 64'hAABB_CCDD);
    req_valid = 1'b0; tick();

    // Read-before-write
    ld_we = 1'b1; ld_adr = 64'd0; ld_data = 32'h1234_5678; ld_be = '1;
    req_valid = 1'b1; req_adr = 64'd0; tick();
    check("rbw_old", 64'(instruction), 64'hFFAA_FFAA);
    ld_we = 1'b0; tick();
    check("rbw_new", 64'(instruction), 64'h1234_5678);
    req_valid = 1'b0; tick();

    // Faulted load and partial byte write
    save62 = m_mem[62]; save63 = m_mem[63];
    ld_we = 1'b1; ld_adr = 64'd62; ld_data = 32'hDEAD_BEEF; tick();
    check("lderr_pulse", 64'(ld_err), 64'd1);
    ld_we = 1'b0; tick();
    check("lderr_clear", 64'(ld_err), 64'd0);
    check("mem62", 64'(dut.u_array.memory[62]), 64'(save62));
    check("mem63", 64'(dut.u_array.memory[63]), 64'(save63));
    ld_we = 1'b1; ld_adr = 64'd4; ld_data = 32'h0000_EE00; ld_be = 4'b0010; tick();
    ld_we = 1'b0; req_valid = 1'b1; req_adr = 64'd4; tick();
    check("partial_be", 64'(instruction), 64'hAABB_EEDD);
    req_valid = 1'b0; tick();

    // Reset discards a pending response, memory survives
    resp_ready = 1'b0; req_valid = 1'b1; req_adr = 64'd0; tick();
    rst = 1'b0; req_valid = 1'b0; tick();
    check("rst_drop", 64'(resp_valid), 64'd0);
    rst = 1'b1; tick();
    check("rst_no_present", 64'(resp_valid), 64'd0);
    resp_ready = 1'b1; req_valid = 1'b1; req_adr = 64'd4; tick();
    check("mem_survives", 64'(instruction), 64'hAABB_EEDD);
    req_valid = 1'b0; tick();

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      rst        = ($urandom_range(0, 49) != 0);
      req_valid  = ($urandom_range(0, 3) != 0);
      resp_ready = ($urandom_range(0, 2) != 0);
      req_adr    = rand_adr();
      ld_we      = ($urandom_range(0, 3) == 0);
      ld_adr     = rand_adr();
      ld_data    = $urandom;
      ld_be      = 4'($urandom_range(0, 15));
      tick();
    end
    rst = 1'b1; req_valid = 1'b0; ld_we = 1'b0; resp_ready = 1'b1; tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/inst_mem_fetch.md
# inst_mem_fetch

Parametrised, byte-addressed instruction memory with a valid/ready fetch port, one-cycle registered read latency, backpressure, and address-fault reporting. A separate byte-enabled load port writes program words. It sits between the PC/fetch stage and the decode stage of the core. It supersedes the fixed-size, combinational-read instruction memory.

## Interface
- ADR_W, 64, address width of `req_adr` and `ld_adr`.
- INST_W, 32, instruction width; must be a multiple of 8; BPI = INST_W/8 bytes per instruction.
- DEPTH, 64, memory size in bytes; must be a multiple of BPI and at least BPI.
- NOP_INST, 32'h0000_0013, instruction returned on any fault.

- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-low.
- req_valid  in  1  fetch request valid.
- req_ready  out  1  fetch request can be accepted this cycle.
- req_adr  in  ADR_W  fetch byte address.
- resp_valid  out  1  `instruction` and `resp_fault` valid.
- resp_ready  in  1  consumer accepts the response.
- instruction  out  INST_W  fetched word, little-endian: byte at adr in bits [7:0].
- resp_fault  out  2  00 ok, 01 misaligned, 10 out-of-range.
- ld_we  in  1  load-port write strobe.
- ld_adr  in  ADR_W  load byte address.
- ld_data  in  INST_W  load data, little-endian.
- ld_be  in  BPI  byte enables; bit i writes byte ld_adr+i.
- ld_err  out  1  registered: previous-cycle write was faulted and dropped.

## Operation
- Fetch handshake: a request is accepted when req_valid && req_ready. `req_ready = !resp_valid || resp_ready`, so it is combinational from resp_ready, and there is no combinational path from req_valid.
- Fault check is done on the full ADR_W width, with no truncation.
  - Out-of-range when adr > DEPTH-BPI. This check has priority.
  - Else misaligned when adr % BPI != 0.
  - On fault: instruction = NOP_INST, and memory is not read.
- Ok response: instruction = {mem[adr+BPI-1], …, mem[adr]}.
- Output register holds instruction and fault stable while resp_valid && !resp_ready. A new request is not accepted in that state.
- Load: when ld_we is high, each enabled byte is written.
  - A faulted write (same rules as fetch) writes nothing and sets ld_err high for exactly one cycle.
  - ld_be == 0 is a legal no-op.
- Memory contents are not cleared by reset. Contents are undefined until loaded.
- Simultaneous load and fetch to the same address: the fetch returns the pre-write data (read-before-write).

## Timing
- Reset (rst low at an edge): resp_valid=0, resp_fault=00, instruction=0, ld_err=0 after that edge.
  - req_ready=1 whenever resp_valid=0.
  - A response pending at reset is discarded.
  - A load in the same cycle as reset is still performed; the load port ignores rst.
- Latency: request accepted at edge N → resp_valid=1 after edge N, i.e. visible in cycle N+1.
- Throughput: one response per cycle when resp_ready is held high (back-to-back requests).
- resp_valid falls after an edge with resp_ready=1 and no new accepted request.
- ld_err is asserted in the cycle following the faulted ld_we.

## Structure
- Package `inst_mem_pkg` contains:
  - `fault_e` enum: FLT_OK=2'b00, FLT_MISALIGN=2'b01, FLT_RANGE=2'b10.
  - Default NOP_INST constant.
  - A shared address-check function (adr, DEPTH, BPI) → fault_e, used by both ports.
- Sub-module `inst_mem_array`: byte array `memory[DEPTH]`, byte-enabled write, combinational word read. The array is named `memory` so benches can preload it hierarchically.
- Top level contains the handshake/output register and the ld_err flop.

## Test plan
- Load 32'hFFAAFFAA at 0 and 32'hAABBCCDD at 4 with ld_be=all 1s; fetch 0 then 4 → FFAAFFAA, AABBCCDD on consecutive cycles, fault 00. memory[0]=8'hAA and memory[7]=8'hAA.
- Fetch 64 with DEPTH=64 → fault 10, instruction 00000013. Fetch 2 → fault 01, instruction 00000013. Fetch 64'hFFFF_FFFF_FFFF_FFFC → fault 10, with no wrap.
- Backpressure:
  - Fetch 0 while resp_ready=0 for 3 cycles → instruction stays FFAAFFAA and req_ready=0.
  - On resp_ready=1, a held request for 4 is accepted and AABBCCDD follows next cycle.
- Same-cycle ld_we to 0 (data 12345678) and fetch 0 → response FFAAFFAA; the next fetch 0 returns 12345678.
- ld_adr=62 with ld_we → ld_err pulses one cycle and memory[62..63] is unchanged. ld_be=4'b0010 at 4 with data 0000EE00 → word 4 reads AABBEEDD.
- Drop rst low while resp_valid=1 → resp_valid=0 next cycle and the pending word is never presented. Memory content survives: fetch 4 after reset returns its prior value.
